// File: rtl/spi_master_if.sv
// Host-side request/response bundle for spi_master: word in with a
// start strobe and ready, received word out with a one-cycle valid.
interface spi_master_if #(
    parameter int p_WORD_LEN = 8
);
    logic [p_WORD_LEN-1:0] inp_data;
    logic                  inp_en;
    logic                  inp_rdy;
    logic [p_WORD_LEN-1:0] out_data;
    logic                  out_valid;

    // Requester side: issues words, consumes results.
    modport master (
        output inp_data,
        output inp_en,
        input  inp_rdy,
        input  out_data,
        input  out_valid
    );

    // spi_master side.
    modport slave (
        input  inp_data,
        input  inp_en,
        output inp_rdy,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, one word per request.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | o_ss high, o_sclk low, ready for a request
// SETUP | o_ss low, first MOSI bit presented, waiting one SCLK phase
// XFER  | SCLK toggling every phase; rising edges sample MISO
// HOLD  | last falling edge done, o_ss held low for one more phase
// GAP   | o_ss high; GAP plus the IDLE sampling cycle give H cycles high
module spi_master #(
    parameter int p_WORD_LEN    = 8,
    parameter int p_HALF_PERIOD = 2
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    output logic         o_sclk,
    output logic         o_mosi,
    input  logic         i_miso,
    output logic         o_ss,
    spi_master_if.slave  host
);
    localparam int W     = p_WORD_LEN;
    localparam int H     = p_HALF_PERIOD;
    localparam int PH_W  = $clog2(H);
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(H - 1);
    localparam logic [PH_W-1:0]  PH_GAP   = PH_W'(H - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             sclk_q, sclk_d;
    logic             ss_q, ss_d;
    logic             mosi_q, mosi_d;
    logic             out_valid_q, out_valid_d;
    logic             phase_tick;

    assign phase_tick = (phase_q == PH_LAST);

    // Register all state and registered outputs; synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state decode; stray encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (host.inp_en) state_d = ST_SETUP;
            ST_SETUP: if (phase_tick) state_d = ST_XFER;
            ST_XFER:  if (phase_tick && sclk_q && (bit_cnt_q == CNT_LAST)) state_d = ST_HOLD;
            ST_HOLD:  if (phase_tick) state_d = ST_GAP;
            ST_GAP:   if (phase_q == PH_GAP) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values for the current state.
    always_comb begin
        phase_d     = phase_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        sclk_d      = sclk_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                ss_d    = 1'b1;
                sclk_d  = 1'b0;
                if (host.inp_en) begin
                    shift_d   = host.inp_data;
                    mosi_d    = host.inp_data[W-1];
                    ss_d      = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (phase_tick) begin
                    sclk_d    = 1'b1;
                    shift_d   = {shift_q[W-2:0], i_miso};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (phase_tick) begin
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        shift_d   = {shift_q[W-2:0], i_miso};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        mosi_d = (bit_cnt_q == CNT_LAST) ? 1'b0 : shift_q[W-1];
                    end
                end
            end
            ST_HOLD: begin
                if (phase_tick) begin
                    ss_d        = 1'b1;
                    out_data_d  = shift_q;
                    out_valid_d = 1'b1;
                end
            end
            ST_GAP: begin
            end
            default: begin
                ss_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
            end
        endcase
        if ((state_d != state_q) || ((state_q == ST_XFER) && phase_tick)) begin
            phase_d = '0;
        end
    end

    assign o_sclk         = sclk_q;
    assign o_ss           = ss_q;
    assign o_mosi         = mosi_q;
    assign host.inp_rdy   = (state_q == ST_IDLE);
    assign host.out_data  = out_data_q;
    assign host.out_valid = out_valid_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: timeline model of one transfer,
// a mode-0 slave, directed scenarios and randomized traffic.
module tb_spi_master;
    localparam int W      = 8;
    localparam int H      = 2;
    localparam int T_BITS = 2 * W * H;
    localparam int T_SS   = (2 * W + 1) * H;
    localparam int T_RDY  = (2 * W + 2) * H - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic miso = 1'b0;
    logic sclk, mosi, ss;

    spi_master_if #(.p_WORD_LEN(W)) host_if ();

    spi_master #(.p_WORD_LEN(W), .p_HALF_PERIOD(H)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .o_sclk (sclk),
        .o_mosi (mosi),
        .i_miso (miso),
        .o_ss   (ss),
        .host   (host_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer is a timeline indexed by t = edges since the start edge.
    bit           m_act = 1'b0;
    int           m_t   = 0;
    logic [W-1:0] m_tx  = '0;
    logic [W-1:0] m_slv = '0;
    logic [W-1:0] m_out = '0;
    bit           force_slv  = 1'b0;
    logic [W-1:0] force_word = '0;
    bit           chk_on = 1'b0;

    always @(posedge clk) begin
        bit rdy_before;
        rdy_before = !m_act || (m_t >= T_RDY);
        if (!rstn) begin
            m_act  = 1'b0;
            m_t    = 0;
            m_out  = '0;
            chk_on = 1'b1;
        end else if (rdy_before && host_if.inp_en) begin
            m_act = 1'b1;
            m_t   = 0;
            m_tx  = host_if.inp_data;
            if (force_slv) begin
                m_slv     = force_word;
                force_slv = 1'b0;
            end else begin
                m_slv = W'($urandom);
            end
        end else if (m_act && (m_t < T_RDY)) begin
            m_t++;
            if (m_t == T_SS) m_out = m_slv;
        end
    end

    function automatic logic exp_ss();
        return !(m_act && (m_t < T_SS));
    endfunction
    function automatic logic exp_sclk();
        return m_act && (m_t >= H) && (m_t < T_BITS) && (((m_t / H) % 2) == 1);
    endfunction
    function automatic logic exp_mosi();
        if (m_act && (m_t < T_BITS)) return m_tx[W - 1 - m_t / (2 * H)];
        return 1'b0;
    endfunction
    function automatic logic exp_valid();
        return m_act && (m_t == T_SS);
    endfunction
    function automatic logic exp_rdy();
        return !m_act || (m_t >= T_RDY);
    endfunction

    // Observers and mode-0 slave state.
    logic         prev_ss = 1'b1, prev_sclk = 1'b0;
    logic [W-1:0] slv_sh = '0, slv_rx = '0, rx_last = '0;
    int slv_bits = W, rises = 0, falls = 0, t_rel = 0;
    int high_cnt = 0, last_high = 0, ss_low_cnt = 0, ss_low_last = 0, ss_rise_t = 0;
    int n_valid = 0, n_start = 0;
    int rise_t [0:W-1];
    int fall_t [0:W-1];

    // Per-cycle compare against the model, then advance slave and observers.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ss", ss, exp_ss());
            chk("sclk", sclk, exp_sclk());
            chk("mosi", mosi, exp_mosi());
            chk("out_valid", host_if.out_valid, exp_valid());
            chk("inp_rdy", host_if.inp_rdy, exp_rdy());
            chk("out_data", host_if.out_data, m_out);
            if (exp_valid()) begin
                chk("slave_rx", slv_rx, m_tx);
                chk("rise_count", rises, W);
            end
            if (host_if.out_valid) n_valid++;
            t_rel++;
            if (!ss && prev_ss) begin
                n_start++;
                last_high  = high_cnt;
                high_cnt   = 0;
                t_rel      = 0;
                rises      = 0;
                falls      = 0;
                ss_low_cnt = 0;
                slv_sh     = m_slv;
                slv_bits   = 0;
                slv_rx     = '0;
            end
            if (!ss) ss_low_cnt++;
            else     high_cnt++;
            if (ss && !prev_ss) begin
                ss_low_last = ss_low_cnt;
                ss_rise_t   = t_rel;
                rx_last     = slv_rx;
            end
            if (!ss && sclk && !prev_sclk) begin
                if (rises < W) rise_t[rises] = t_rel;
                rises++;
                slv_rx = {slv_rx[W-2:0], mosi};
            end
            if (!ss && !sclk && prev_sclk) begin
                if (falls < W) fall_t[falls] = t_rel;
                falls++;
                slv_sh = slv_sh << 1;
                slv_bits++;
            end
            if (!ss && (slv_bits < W)) miso = slv_sh[W-1];
            else                       miso = 1'($urandom_range(0, 1));
            prev_ss   = ss;
            prev_sclk = sclk;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int v0, s0;
        host_if.inp_en   = 1'b0;
        host_if.inp_data = '0;
        rstn = 1'b0;
        step(3);
        chk("rst_ss", ss, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_out_data", host_if.out_data, 0);
        chk("rst_out_valid", host_if.out_valid, 0);
        chk("rst_inp_rdy", host_if.inp_rdy, 1);
        rstn = 1'b1;
        step(1);

        // Loopback 0xA5 out, 0x3C in, with edge timing.
        v0 = n_valid;
        force_word = 8'h3C;
        force_slv  = 1'b1;
        host_if.inp_data = 8'hA5;
        host_if.inp_en   = 1'b1;
        step(1);
        host_if.inp_en = 1'b0;
        step(40);
        chk("lb_out_data", host_if.out_data, 8'h3C);
        chk("lb_slave_rx", rx_last, 8'hA5);
        chk("lb_valid_pulses", n_valid - v0, 1);
        chk("lb_ss_low", ss_low_last, 34);
        chk("lb_ss_rise_t", ss_rise_t, 34);
        for (int k = 1; k <= W; k++) begin
            chk("lb_rise_t", rise_t[k-1], (2 * k - 1) * H);
            chk("lb_fall_t", fall_t[k-1], 2 * k * H);
        end

        // Request while busy is dropped.
        v0 = n_valid;
        s0 = n_start;
        host_if.inp_data = 8'h12;
        host_if.inp_en   = 1'b1;
        step(1);
        host_if.inp_en = 1'b0;
        step(10);
        host_if.inp_data = 8'hFF;
        host_if.inp_en   = 1'b1;
        step(1);
        host_if.inp_en = 1'b0;
        step(40);
        chk("busy_slave_rx", rx_last, 8'h12);
        chk("busy_valid_pulses", n_valid - v0, 1);
        chk("busy_starts", n_start - s0, 1);

        // Back-to-back with inp_en held.
        v0 = n_valid;
        s0 = n_start;
        host_if.inp_data = 8'h81;
        host_if.inp_en   = 1'b1;
        step(1);
        host_if.inp_data = 8'h7E;
        step(T_RDY + 1);
        host_if.inp_en = 1'b0;
        step(40);
        chk("b2b_valid_pulses", n_valid - v0, 2);
        chk("b2b_starts", n_start - s0, 2);
        chk("b2b_ss_high_gap", last_high, H);
        chk("b2b_slave_rx", rx_last, 8'h7E);

        // Reset after the 4th rising edge aborts the transfer.
        v0 = n_valid;
        host_if.inp_data = W'($urandom);
        host_if.inp_en   = 1'b1;
        step(1);
        host_if.inp_en = 1'b0;
        for (int i = 0; i < 100 && rises != 4; i++) step(1);
        chk("abort_reached_rise4", rises, 4);
        rstn = 1'b0;
        step(1);
        chk("abort_ss", ss, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_out_data", host_if.out_data, 0);
        rstn = 1'b1;
        step(1);
        chk("abort_inp_rdy", host_if.inp_rdy, 1);
        step(40);
        chk("abort_no_valid", n_valid - v0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rstn             = ($urandom_range(0, 399) != 0);
            host_if.inp_en   = ($urandom_range(0, 2) == 0);
            host_if.inp_data = W'($urandom);
            step(1);
        end
        rstn           = 1'b1;
        host_if.inp_en = 1'b0;
        step(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
